// File: rtl/lib_rsp_router_pkg.sv
// Shared sizing helpers and tag type for the response router slice.
package lib_rsp_router_pkg;

  localparam int unsigned MAX_PORTS = 16;
  localparam int unsigned MAX_TAG_W = 4;

  typedef logic [MAX_TAG_W-1:0] tag_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lib_rsp_router_if.sv
// Grant/response/fan-out bundle between the arbiter side, downstream bus and requesters.
interface lib_rsp_router_if
  import lib_rsp_router_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned LNUM_PORTS = idx_width(NUM_PORTS),
  parameter int unsigned DATA_W     = 64
);

  logic                  grant_valid;
  logic [LNUM_PORTS-1:0] grant_select;
  logic                  grant_ready;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_data;
  logic                  rsp_last;
  logic                  rsp_ready;
  logic [NUM_PORTS-1:0]  out_valid;
  logic [DATA_W-1:0]     out_data;
  logic                  out_last;
  logic [NUM_PORTS-1:0]  out_ready;

  modport slave (
    input  grant_valid, grant_select, rsp_valid, rsp_data, rsp_last, out_ready,
    output grant_ready, rsp_ready, out_valid, out_data, out_last
  );

  modport master (
    output grant_valid, grant_select, rsp_valid, rsp_data, rsp_last, out_ready,
    input  grant_ready, rsp_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/lib_tag_fifo.sv
// In-order tag FIFO: flop array with full/empty/count, no write-to-read bypass.
module lib_tag_fifo
  import lib_rsp_router_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TAG_W = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        push,
  input  logic [TAG_W-1:0]            push_tag,
  input  logic                        pop,
  output logic [TAG_W-1:0]            head,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_q];
  assign count   = cnt_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so pointer increments wrap DEPTH-1 -> 0 on their own.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_tag;
      wr_d        = wr_q + PW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lib_rsp_router.sv
// Steers in-order responses back to the port recorded at grant time.
// Optional sticky error flag: define LIB_RSP_ROUTER_ERR_CHK_EN.
module lib_rsp_router
  import lib_rsp_router_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned LNUM_PORTS = idx_width(NUM_PORTS),
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_W     = 64
) (
  input  logic                        clk,
  input  logic                        reset_n,
  lib_rsp_router_if.slave             bus,
  output logic [cnt_width(DEPTH)-1:0] outstanding,
  output logic                        err_unexp_rsp
);

  logic [LNUM_PORTS-1:0] head;
  logic                  full, empty, push, pop;
  logic [NUM_PORTS-1:0]  sel;

  assign push = bus.grant_valid && !full;
  assign pop  = bus.rsp_valid && bus.rsp_ready && bus.rsp_last;

  lib_tag_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (LNUM_PORTS)
  ) u_tag_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_tag (bus.grant_select),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (outstanding)
  );

  always_comb begin
    sel = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      sel[p] = !empty && (head == LNUM_PORTS'(p));
    end
  end

  assign bus.grant_ready = !full;
  assign bus.out_valid   = bus.rsp_valid ? sel : '0;
  assign bus.rsp_ready   = |(sel & bus.out_ready);
  assign bus.out_data    = DATA_W'(bus.rsp_data);
  assign bus.out_last    = bus.rsp_last;

  a_sel_legal: assert property (@(posedge clk) disable iff (!reset_n)
    bus.grant_valid |-> (bus.grant_select < NUM_PORTS));
  a_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(bus.out_valid));

`ifdef LIB_RSP_ROUTER_ERR_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (bus.rsp_valid & empty) | (bus.grant_valid & full);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err_unexp_rsp = err_q;

  a_err_sticky: assert property (@(posedge clk) disable iff (!reset_n)
    err_q |=> err_q);
`else
  assign err_unexp_rsp = 1'b0;
`endif

endmodule

// File: tb/tb_lib_rsp_router.sv
// Self-checking bench for lib_rsp_router: directed table plus randomized traffic vs a queue model.
module tb_lib_rsp_router;

  localparam int unsigned NP    = 4;
  localparam int unsigned DEPTH = 16;

  typedef struct {
    bit          rst_n;
    bit          gv;
    logic [1:0]  gs;
    bit          rv;
    logic [63:0] rd;
    bit          rl;
    logic [3:0]  ordy;
    logic [3:0]  e_ov;
    bit          e_rr;
    bit          e_gr;
    logic [4:0]  e_out;
    bit          e_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] outstanding;
  logic       err_unexp_rsp;

  lib_rsp_router_if #(.NUM_PORTS(NP), .DATA_W(64)) bus ();

  lib_rsp_router #(
    .NUM_PORTS (NP),
    .DEPTH     (DEPTH),
    .DATA_W    (64)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .outstanding   (outstanding),
    .err_unexp_rsp (err_unexp_rsp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int q[$];
  bit m_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rst_n, bit gv, logic [1:0] gs, bit rv, logic [63:0] rd, bit rl,
                              logic [3:0] ordy, logic [3:0] e_ov, bit e_rr, bit e_gr,
                              logic [4:0] e_out, bit e_err);
    vec_t v;
    v.rst_n = rst_n; v.gv = gv; v.gs = gs; v.rv = rv; v.rd = rd; v.rl = rl; v.ordy = ordy;
    v.e_ov = e_ov; v.e_rr = e_rr; v.e_gr = e_gr; v.e_out = e_out; v.e_err = e_err;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset_n          = v.rst_n;
    bus.grant_valid  = v.gv;
    bus.grant_select = v.gs;
    bus.rsp_valid    = v.rv;
    bus.rsp_data     = v.rd;
    bus.rsp_last     = v.rl;
    bus.out_ready    = v.ordy;
  endtask

  // One clock: compare at negedge against the model (and optional table row), then advance model.
  task automatic tick(input bit use_tbl, input vec_t v, input string tag);
    bit         m_empty, m_full, m_rr, m_err_exp;
    int         hd;
    logic [3:0] m_ov;
    @(negedge clk);
    m_empty = (q.size() == 0);
    m_full  = (q.size() == DEPTH);
    hd      = m_empty ? 0 : q[0];
    m_ov    = (bus.rsp_valid && !m_empty) ? (4'b0001 << hd) : 4'b0000;
    m_rr    = !m_empty && bus.out_ready[hd];
`ifdef LIB_RSP_ROUTER_ERR_CHK_EN
    m_err_exp = m_err;
`else
    m_err_exp = 1'b0;
`endif
    if (cmp_en) begin
      chk({tag, ".m_out_valid"},   bus.out_valid,   m_ov);
      chk({tag, ".m_rsp_ready"},   bus.rsp_ready,   m_rr);
      chk({tag, ".m_grant_ready"}, bus.grant_ready, !m_full);
      chk({tag, ".m_outstanding"}, outstanding,     q.size());
      chk({tag, ".m_out_data"},    bus.out_data,    bus.rsp_data);
      chk({tag, ".m_out_last"},    bus.out_last,    bus.rsp_last);
      chk({tag, ".m_err"},         err_unexp_rsp,   m_err_exp);
    end
    if (use_tbl) begin
      chk({tag, ".out_valid"},   bus.out_valid,   v.e_ov);
      chk({tag, ".rsp_ready"},   bus.rsp_ready,   v.e_rr);
      chk({tag, ".grant_ready"}, bus.grant_ready, v.e_gr);
      chk({tag, ".outstanding"}, outstanding,     v.e_out);
      chk({tag, ".out_data"},    bus.out_data,    v.rd);
`ifdef LIB_RSP_ROUTER_ERR_CHK_EN
      chk({tag, ".err"}, err_unexp_rsp, v.e_err);
`else
      chk({tag, ".err"}, err_unexp_rsp, 1'b0);
`endif
    end
    if (!reset_n) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      m_err = m_err | (bus.rsp_valid && m_empty) | (bus.grant_valid && m_full);
      if (bus.rsp_valid && m_rr && bus.rsp_last) void'(q.pop_front());
      if (bus.grant_valid && !m_full) q.push_back(int'(bus.grant_select));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    vec_t r;
    r = mk(0, 0, 0, 0, 64'h0, 0, 4'h0, 0, 0, 0, 0, 0);
    drive(r);
    tick(0, r, "rst");
    tick(0, r, "rst");
  endtask

  vec_t tbl[18];
  vec_t v;

  initial begin
    tbl[0]  = mk(1, 1, 2, 0, 64'h0,              0, 4'hF, 4'b0000, 0, 1, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 64'h0,              0, 4'hF, 4'b0000, 1, 1, 1, 0);
    tbl[2]  = mk(1, 1, 3, 0, 64'h0,              0, 4'hF, 4'b0000, 1, 1, 2, 0);
    tbl[3]  = mk(1, 0, 0, 1, 64'hAAAA_0000_0000_000A, 1, 4'hF, 4'b0100, 1, 1, 3, 0);
    tbl[4]  = mk(1, 0, 0, 1, 64'hBBBB_0000_0000_000B, 1, 4'hF, 4'b0001, 1, 1, 2, 0);
    tbl[5]  = mk(1, 0, 0, 1, 64'hCCCC_0000_0000_000C, 1, 4'hF, 4'b1000, 1, 1, 1, 0);
    tbl[6]  = mk(1, 0, 0, 0, 64'h0,              0, 4'hF, 4'b0000, 0, 1, 0, 0);
    tbl[7]  = mk(1, 1, 1, 0, 64'h0,              0, 4'hF, 4'b0000, 0, 1, 0, 0);
    tbl[8]  = mk(1, 0, 0, 1, 64'hD0D0_D0D0_0000_0001, 0, 4'b0010, 4'b0010, 1, 1, 1, 0);
    tbl[9]  = mk(1, 0, 0, 1, 64'hD1D1_D1D1_0000_0002, 0, 4'b1101, 4'b0010, 0, 1, 1, 0);
    tbl[10] = mk(1, 0, 0, 1, 64'hD1D1_D1D1_0000_0002, 0, 4'b0010, 4'b0010, 1, 1, 1, 0);
    tbl[11] = mk(1, 0, 0, 1, 64'hD2D2_D2D2_0000_0003, 0, 4'b0010, 4'b0010, 1, 1, 1, 0);
    tbl[12] = mk(1, 0, 0, 1, 64'hD3D3_D3D3_0000_0004, 1, 4'b0010, 4'b0010, 1, 1, 1, 0);
    tbl[13] = mk(1, 0, 0, 0, 64'h0,              0, 4'b0010, 4'b0000, 0, 1, 0, 0);
    tbl[14] = mk(1, 1, 3, 1, 64'hEEEE_0000_0000_000E, 1, 4'hF, 4'b0000, 0, 1, 0, 0);
    tbl[15] = mk(1, 0, 0, 1, 64'hEEEE_0000_0000_000E, 1, 4'hF, 4'b1000, 1, 1, 1, 1);
    tbl[16] = mk(1, 0, 0, 0, 64'h0,              0, 4'hF, 4'b0000, 0, 1, 0, 1);
    tbl[17] = mk(1, 0, 0, 1, 64'h1234_5678_9ABC_DEF0, 1, 4'hF, 4'b0000, 0, 1, 0, 1);

    do_reset();
    cmp_en = 1'b1;

    // Directed table: 3 single-beat routes, 4-beat stall, same-cycle push+rsp, empty rsp.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i]);
      tick(1, tbl[i], $sformatf("tbl%0d", i));
    end

    // Fill to DEPTH, then pop and push+pop at the full boundary.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      v = mk(1, 1, 2'(i % 4), 0, 64'h0, 0, 4'hF, 0, 0, 0, 0, 0);
      drive(v);
      tick(0, v, $sformatf("fill%0d", i));
    end
    v = mk(1, 0, 0, 1, 64'h0F0F, 1, 4'hF, 4'b0001, 1, 0, 16, 0);
    drive(v); tick(1, v, "full_pop");
    v = mk(1, 1, 1, 1, 64'h1F1F, 1, 4'hF, 4'b0010, 1, 1, 15, 0);
    drive(v); tick(1, v, "push_pop");
    v = mk(1, 0, 0, 0, 64'h0, 0, 4'hF, 4'b0000, 1, 1, 15, 0);
    drive(v); tick(1, v, "after_push_pop");

    // Reset in the middle of a multi-beat response with 5 outstanding.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      v = mk(1, 1, 2'(i % 4), 0, 64'h0, 0, 4'hF, 0, 0, 0, 0, 0);
      drive(v);
      tick(0, v, $sformatf("pre%0d", i));
    end
    v = mk(1, 0, 0, 1, 64'h5555, 0, 4'hF, 4'b0001, 1, 1, 5, 0);
    drive(v); tick(1, v, "mid_beat");
    v = mk(0, 0, 0, 1, 64'h6666, 0, 4'hF, 0, 0, 0, 0, 0);
    drive(v); tick(0, v, "mid_rst");
    v = mk(1, 0, 0, 1, 64'h7777, 0, 4'hF, 4'b0000, 0, 1, 0, 0);
    drive(v); tick(1, v, "post_rst");

    // Randomized traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      v.rst_n = ($urandom_range(0, 299) != 0);
      v.gv    = ($urandom_range(0, 1) == 1);
      v.gs    = 2'($urandom_range(0, NP - 1));
      v.rv    = ($urandom_range(0, 9) < 6);
      v.rd    = {$urandom, $urandom};
      v.rl    = ($urandom_range(0, 4) < 2);
      v.ordy  = 4'($urandom_range(0, 15));
      drive(v);
      tick(0, v, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
